// File: rtl/tlb_pkg.sv
// Shared types for the TLB walk frontend: default widths, walk FSM states
// and the CAM entry layout.
package tlb_pkg;

  localparam int DEF_VPN_W = 3;
  localparam int DEF_PTE_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FILL,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_VPN_W-1:0] vpn;
    logic [DEF_PTE_W-1:0] pte;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_walk_frontend_cam.sv
// Fully-associative entry store: parallel VPN match, lowest free slot search,
// single write port and a flush that clears every valid bit.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DEF_VPN_W-1:0] lookup_vpn,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [DEF_PTE_W-1:0] hit_pte,
  output logic                 free_valid,
  output logic [IDX_W-1:0]     free_idx,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DEF_VPN_W-1:0] wr_vpn,
  input  logic [DEF_PTE_W-1:0] wr_pte
);

  tlb_entry_t entries_reg [ENTRIES];
  logic [ENTRIES-1:0] match;
  logic [ENTRIES-1:0] invalid;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign match[gi]   = entries_reg[gi].valid && (entries_reg[gi].vpn == lookup_vpn);
    assign invalid[gi] = !entries_reg[gi].valid;
  end

  // Flush outranks a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) entries_reg[i].valid <= 1'b0;
    end else if (wr_en) begin
      entries_reg[wr_idx] <= '{valid: 1'b1, vpn: wr_vpn, pte: wr_pte};
    end
  end

  // At most one entry matches, since a fill only happens after a miss.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    hit_pte = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) begin
        hit_idx = IDX_W'(i);
        hit_pte = entries_reg[i].pte;
      end
    end
  end

  always_comb begin
    free_valid = |invalid;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (invalid[i]) free_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlb_walk_frontend.sv
// TLB front end: answers hits locally, walks the page table on a miss,
// fills an entry from the returned translation and keeps hit/miss statistics.
module tlb_walk_frontend
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = DEF_VPN_W,
  parameter int PTE_W   = DEF_PTE_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ready,
  input  logic             flush,
  output logic             resp_valid,
  output logic [PTE_W-1:0] resp_pte,
  output logic             resp_hit,
  output logic             resp_err,
  output logic             pt_lookup_rqst,
  output logic [VPN_W-1:0] pt_lookup_addr,
  input  logic             pt_lookup_complete,
  input  logic [PTE_W-1:0] pt_lookup_return,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  state_t             state_reg;
  logic [VPN_W-1:0]   vpn_reg;
  logic [PTE_W-1:0]   pte_reg;
  logic               flushed_reg;
  logic [WCNT_W-1:0]  wcnt_reg;
  logic [IDX_W-1:0]   repl_reg;
  logic               resp_valid_reg;
  logic [PTE_W-1:0]   resp_pte_reg;
  logic               resp_hit_reg;
  logic               resp_err_reg;
  logic [CNT_W-1:0]   hit_cnt_reg;
  logic [CNT_W-1:0]   miss_cnt_reg;

  logic               cam_hit;
  logic [IDX_W-1:0]   cam_hit_idx_unused;
  logic [PTE_W-1:0]   cam_hit_pte;
  logic               cam_free_valid;
  logic [IDX_W-1:0]   cam_free_idx;
  logic               cam_wr_en;
  logic [IDX_W-1:0]   cam_wr_idx;

  // A flush seen anywhere during the walk means the returned translation may be stale.
  assign cam_wr_en  = (state_reg == ST_FILL) && !flushed_reg && !flush;
  assign cam_wr_idx = cam_free_valid ? cam_free_idx : repl_reg;

  tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .lookup_vpn (req_vpn),
    .hit        (cam_hit),
    .hit_idx    (cam_hit_idx_unused),
    .hit_pte    (cam_hit_pte),
    .free_valid (cam_free_valid),
    .free_idx   (cam_free_idx),
    .wr_en      (cam_wr_en),
    .wr_idx     (cam_wr_idx),
    .wr_vpn     (vpn_reg),
    .wr_pte     (pte_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      vpn_reg        <= '0;
      pte_reg        <= '0;
      flushed_reg    <= 1'b0;
      wcnt_reg       <= '0;
      repl_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_pte_reg   <= '0;
      resp_hit_reg   <= 1'b0;
      resp_err_reg   <= 1'b0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_pte_reg   <= '0;
      resp_hit_reg   <= 1'b0;
      resp_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            vpn_reg <= req_vpn;
            // A same-cycle flush turns what would be a hit into a miss.
            if (cam_hit && !flush) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_hit_reg   <= 1'b1;
              resp_pte_reg   <= cam_hit_pte;
              if (hit_cnt_reg != {CNT_W{1'b1}}) hit_cnt_reg <= hit_cnt_reg + 1'b1;
            end else begin
              state_reg   <= ST_ISSUE;
              flushed_reg <= 1'b0;
              if (miss_cnt_reg != {CNT_W{1'b1}}) miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
          wcnt_reg  <= '0;
          if (flush) flushed_reg <= 1'b1;
        end
        ST_WAIT: begin
          if (flush) flushed_reg <= 1'b1;
          if (pt_lookup_complete) begin
            pte_reg   <= pt_lookup_return;
            state_reg <= ST_FILL;
          end else if (wcnt_reg == WCNT_W'(TIMEOUT)) begin
            state_reg      <= ST_RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
          end else begin
            wcnt_reg <= wcnt_reg + 1'b1;
          end
        end
        ST_FILL: begin
          state_reg      <= ST_RESP;
          resp_valid_reg <= 1'b1;
          resp_pte_reg   <= pte_reg;
          if (cam_wr_en && !cam_free_valid) repl_reg <= repl_reg + 1'b1;
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_reg == ST_IDLE);
  assign pt_lookup_rqst = (state_reg == ST_ISSUE);
  assign pt_lookup_addr = (state_reg == ST_ISSUE || state_reg == ST_WAIT) ? vpn_reg : '0;
  assign resp_valid     = resp_valid_reg;
  assign resp_pte       = resp_pte_reg;
  assign resp_hit       = resp_hit_reg;
  assign resp_err       = resp_err_reg;
  assign hit_cnt        = hit_cnt_reg;
  assign miss_cnt       = miss_cnt_reg;

endmodule
